// File: rtl/delay_sa.sv
// Delay stage of the synthetic-aperture beamformer: buffers one sample per channel per beat
// and serialises the per-channel delayed samples to the downstream summer.
module delay_sa #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_DELAY    = 16,
  parameter int DLY_W        = $clog2(MAX_DELAY),
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_frame,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_in,
  input  logic                               delay_wr_en,
  input  logic [CH_W-1:0]                    delay_wr_ch,
  input  logic [DLY_W-1:0]                   delay_wr_val,
  output logic                               busy,
  output logic                               start_sum,
  output logic                               sum_en,
  output logic [DATA_WIDTH-1:0]              delayed_sample,
  output logic                               done_channel
);

  localparam int FILL_W = $clog2(MAX_DELAY + 1);

  typedef enum logic [1:0] {IDLE, START, EMIT, DONE} state_t;

  state_t                  state_q;
  logic [DLY_W-1:0]        wrPtr_q;
  logic [DLY_W-1:0]        curPtr_q;
  logic [FILL_W-1:0]       fill_q;
  logic [CH_W-1:0]         ch_q;
  logic [DLY_W-1:0]        delay_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   mem_q [NUM_CHANNELS][MAX_DELAY];
  logic                    busy_q;
  logic                    startSum_q;
  logic                    sumEn_q;
  logic [DATA_WIDTH-1:0]   delayed_q;
  logic                    done_q;

  logic                    accept;
  logic [DLY_W-1:0]        wrIdx;
  logic [DLY_W-1:0]        wrPtr_d;
  logic [FILL_W-1:0]       baseFill;
  logic [FILL_W-1:0]       fill_d;
  logic [CH_W-1:0]         rdCh;
  logic [DLY_W-1:0]        rdDly;
  logic [DLY_W-1:0]        rdIdx;
  logic [DATA_WIDTH-1:0]   rdData;

  assign sample_ready   = (state_q == IDLE);
  assign accept         = sample_ready && sample_valid;
  assign busy           = busy_q;
  assign start_sum      = startSum_q;
  assign sum_en         = sumEn_q;
  assign delayed_sample = delayed_q;
  assign done_channel   = done_q;

  // A frame strobe coinciding with an accept clears history before the beat lands.
  always_comb begin
    wrIdx    = start_frame ? '0 : wrPtr_q;
    baseFill = start_frame ? '0 : fill_q;
    wrPtr_d  = (int'(wrIdx) == MAX_DELAY - 1) ? '0 : wrIdx + DLY_W'(1);
    fill_d   = (int'(baseFill) == MAX_DELAY) ? baseFill : baseFill + FILL_W'(1);
  end

  // Look up the sample for the channel presented next; explicit modulo so any depth works.
  always_comb begin
    rdCh   = (state_q == START) ? '0 : ch_q + CH_W'(1);
    rdDly  = '0;
    rdIdx  = '0;
    rdData = '0;
    if (int'(rdCh) < NUM_CHANNELS) begin
      rdDly = delay_q[rdCh];
      if (curPtr_q >= rdDly) begin
        rdIdx = curPtr_q - rdDly;
      end else begin
        rdIdx = DLY_W'(int'(curPtr_q) + MAX_DELAY - int'(rdDly));
      end
      if (int'(fill_q) > int'(rdDly)) begin
        rdData = mem_q[rdCh][rdIdx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        mem_q[k][wrIdx] <= sample_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      curPtr_q   <= '0;
      fill_q     <= '0;
      ch_q       <= '0;
      busy_q     <= 1'b0;
      startSum_q <= 1'b0;
      sumEn_q    <= 1'b0;
      delayed_q  <= '0;
      done_q     <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        delay_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (delay_wr_en && (int'(delay_wr_ch) < NUM_CHANNELS)) begin
            delay_q[delay_wr_ch] <= delay_wr_val;
          end
          if (accept) begin
            curPtr_q   <= wrIdx;
            wrPtr_q    <= wrPtr_d;
            fill_q     <= fill_d;
            busy_q     <= 1'b1;
            startSum_q <= 1'b1;
            state_q    <= START;
          end else if (start_frame) begin
            wrPtr_q <= '0;
            fill_q  <= '0;
          end
        end
        START: begin
          startSum_q <= 1'b0;
          sumEn_q    <= 1'b1;
          delayed_q  <= rdData;
          ch_q       <= '0;
          state_q    <= EMIT;
        end
        EMIT: begin
          if (int'(ch_q) == NUM_CHANNELS - 1) begin
            sumEn_q   <= 1'b0;
            delayed_q <= '0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            delayed_q <= rdData;
            ch_q      <= ch_q + CH_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sa.sv
// Self-checking bench for delay_sa: a reference history model feeds a scoreboard of
// expected delayed samples, alongside per-scenario timing and handshake checks.
module tb_delay_sa;

  localparam int DW    = 16;
  localparam int NC    = 4;
  localparam int MD    = 16;
  localparam int DLY_W = 4;
  localparam int CH_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_frame = 1'b0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic [NC*DW-1:0]  sample_in = '0;
  logic              delay_wr_en = 1'b0;
  logic [CH_W-1:0]   delay_wr_ch = '0;
  logic [DLY_W-1:0]  delay_wr_val = '0;
  logic              busy;
  logic              start_sum;
  logic              sum_en;
  logic [DW-1:0]     delayed_sample;
  logic              done_channel;

  int testsRun = 0;
  int failures = 0;

  logic [NC*DW-1:0] histQ[$];
  logic [DW-1:0]    expQ[$];
  int               modelDelay[NC];

  delay_sa #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MAX_DELAY(MD)) dut (
    .clk(clk), .reset(reset), .start_frame(start_frame),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_in(sample_in),
    .delay_wr_en(delay_wr_en), .delay_wr_ch(delay_wr_ch), .delay_wr_val(delay_wr_val),
    .busy(busy), .start_sum(start_sum), .sum_en(sum_en),
    .delayed_sample(delayed_sample), .done_channel(done_channel)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] modelOut(int k);
    logic [NC*DW-1:0] b;
    int n = histQ.size();
    if (n > modelDelay[k]) begin
      b = histQ[n-1-modelDelay[k]];
      return b[k*DW +: DW];
    end
    return '0;
  endfunction

  function automatic logic [NC*DW-1:0] mkBeat(int b);
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = DW'(100*b + k);
    return v;
  endfunction

  // Model update for one accepted beat: optional history clear, then queue expectations.
  task automatic recordAccept(input logic [NC*DW-1:0] beat, input logic sf);
    if (sf) histQ.delete();
    histQ.push_back(beat);
    if (histQ.size() > MD) void'(histQ.pop_front());
    for (int k = 0; k < NC; k++) expQ.push_back(modelOut(k));
  endtask

  task automatic scoreboardMonitor();
    logic [DW-1:0] exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        testsRun++;
        if (sum_en) begin
          if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected: got sample %0d, required no sum_en", delayed_sample);
          end else begin
            exp = expQ.pop_front();
            if (delayed_sample !== exp) begin
              failures++;
              $display("[TB] FAIL sb_sample: got %0d, required %0d", delayed_sample, exp);
            end
          end
        end else if (delayed_sample !== '0) begin
          failures++;
          $display("[TB] FAIL sb_idle_zero: got %0d, required 0", delayed_sample);
        end
      end
    end
  endtask

  task automatic sendBeat(input logic [NC*DW-1:0] beat, input logic sf);
    int n = 0;
    @(negedge clk);
    while (!sample_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL ready_timeout: got sample_ready=0, required 1");
      return;
    end
    sample_valid = 1'b1;
    sample_in    = beat;
    start_frame  = sf;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    start_frame  = 1'b0;
    recordAccept(beat, sf);
  endtask

  task automatic setDelay(input int ch, input int val, input bit applies);
    @(negedge clk);
    delay_wr_en  = 1'b1;
    delay_wr_ch  = CH_W'(ch);
    delay_wr_val = DLY_W'(val);
    @(posedge clk);
    #1;
    delay_wr_en = 1'b0;
    if (applies) modelDelay[ch] = val;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while ((busy || expQ.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    testsRun++;
    if (busy || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d, required 0/0", busy, expQ.size());
    end
  endtask

  task automatic captureEmission(output logic [NC*DW-1:0] v);
    v = '0;
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      v[k*DW +: DW] = delayed_sample;
    end
  endtask

  task automatic test_reset();
    int doneCnt = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({sample_ready, busy, start_sum, sum_en, done_channel} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b, required 10000",
               {sample_ready, busy, start_sum, sum_en, done_channel});
    end
    testsRun++;
    if (delayed_sample !== '0) begin
      failures++;
      $display("[TB] FAIL reset_sample: got %0d, required 0", delayed_sample);
    end
    reset = 1'b1;
    for (int k = 0; k < NC; k++) setDelay(k, k, 1);
    sendBeat(mkBeat(7), 1'b1);
    sendBeat(mkBeat(8), 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    testsRun++;
    if ({sample_ready, busy, start_sum, sum_en, done_channel} !== 5'b10000 || delayed_sample !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: got flags %b sample %0d, required 10000 and 0",
               {sample_ready, busy, start_sum, sum_en, done_channel}, delayed_sample);
    end
    expQ.delete();
    histQ.delete();
    for (int k = 0; k < NC; k++) modelDelay[k] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NC + 3; i++) begin
      @(negedge clk);
      if (done_channel) doneCnt++;
    end
    testsRun++;
    if (doneCnt != 0) begin
      failures++;
      $display("[TB] FAIL abort_done: got %0d done pulses, required 0", doneCnt);
    end
    for (int k = 0; k < NC; k++) setDelay(k, k, 1);
    sendBeat(mkBeat(9), 1'b0);
    waitIdle();
  endtask

  task automatic test_zero_delay();
    int sum = 0;
    int sawEn = 0;
    for (int k = 0; k < NC; k++) setDelay(k, 0, 1);
    sendBeat({16'd5230, 16'd125, 16'd20, 16'd237}, 1'b0);
    @(negedge clk);
    testsRun++;
    if (start_sum !== 1'b1 || sum_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zd_start: got start_sum=%b sum_en=%b, required 1/0", start_sum, sum_en);
    end
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      if (sum_en === 1'b1 && start_sum === 1'b0) sawEn++;
      sum += int'(delayed_sample);
    end
    testsRun++;
    if (sawEn != NC) begin
      failures++;
      $display("[TB] FAIL zd_sum_en_cycles: got %0d, required %0d", sawEn, NC);
    end
    testsRun++;
    if (sum != 5612) begin
      failures++;
      $display("[TB] FAIL zd_sum: got %0d, required 5612", sum);
    end
    @(negedge clk);
    testsRun++;
    if (done_channel !== 1'b1 || sum_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zd_done: got done=%b sum_en=%b, required 1/0", done_channel, sum_en);
    end
    @(negedge clk);
    testsRun++;
    if (sample_ready !== 1'b1 || busy !== 1'b0 || done_channel !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zd_ready: got ready=%b busy=%b done=%b, required 1/0/0",
               sample_ready, busy, done_channel);
    end
  endtask

  task automatic test_per_channel();
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) setDelay(k, k, 1);
    for (int b = 0; b < 3; b++) sendBeat(mkBeat(b), (b == 0));
    sendBeat(mkBeat(3), 1'b0);
    captureEmission(v);
    testsRun++;
    if (v !== {16'd3, 16'd102, 16'd201, 16'd300}) begin
      failures++;
      $display("[TB] FAIL per_channel_b3: got %h, required %h", v, {16'd3, 16'd102, 16'd201, 16'd300});
    end
    waitIdle();
  endtask

  task automatic test_wrap();
    logic [NC*DW-1:0] beat;
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) setDelay(k, (k == 2) ? 15 : 0, 1);
    for (int b = 0; b < 40; b++) begin
      beat = {DW'($urandom), DW'(b), DW'($urandom), DW'($urandom)};
      sendBeat(beat, (b == 0));
    end
    captureEmission(v);
    testsRun++;
    if (v[2*DW +: DW] !== 16'd24) begin
      failures++;
      $display("[TB] FAIL wrap_b39: got %0d, required 24", v[2*DW +: DW]);
    end
    waitIdle();
  endtask

  task automatic test_back_to_back();
    int acceptCyc[$];
    logic rdy;
    logic [NC*DW-1:0] beat;
    int badGap = 0;
    for (int k = 0; k < NC; k++) setDelay(k, k % 2, 1);
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      beat = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
      sample_in    = beat;
      sample_valid = 1'b1;
      rdy          = sample_ready;
      @(posedge clk);
      if (rdy) begin
        recordAccept(beat, 1'b0);
        acceptCyc.push_back(c);
      end
    end
    #1 sample_valid = 1'b0;
    testsRun++;
    if (acceptCyc.size() != 4) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d accepts, required 4", acceptCyc.size());
    end
    for (int i = 1; i < acceptCyc.size(); i++) begin
      if (acceptCyc[i] - acceptCyc[i-1] != NC + 3) badGap++;
    end
    testsRun++;
    if (badGap != 0) begin
      failures++;
      $display("[TB] FAIL b2b_spacing: got %0d wrong gaps, required 0 (period %0d)", badGap, NC + 3);
    end
    waitIdle();
  endtask

  task automatic test_busy_ignores();
    for (int k = 0; k < NC; k++) setDelay(k, k, 1);
    sendBeat(mkBeat(11), 1'b1);
    setDelay(1, 7, 0);
    @(negedge clk);
    start_frame = 1'b1;
    @(posedge clk);
    #1 start_frame = 1'b0;
    sendBeat(mkBeat(12), 1'b0);
    sendBeat(mkBeat(13), 1'b0);
    waitIdle();
  endtask

  task automatic test_frame_clear();
    logic [NC*DW-1:0] v;
    sendBeat(mkBeat(20), 1'b1);
    captureEmission(v);
    testsRun++;
    if (v !== {16'd0, 16'd0, 16'd0, 16'd2000}) begin
      failures++;
      $display("[TB] FAIL frame_clear: got %h, required %h", v, {16'd0, 16'd0, 16'd0, 16'd2000});
    end
    waitIdle();
  endtask

  initial begin
    for (int k = 0; k < NC; k++) modelDelay[k] = 0;
    fork
      scoreboardMonitor();
    join_none
    test_reset();
    test_zero_delay();
    test_per_channel();
    test_wrap();
    test_back_to_back();
    test_busy_ignores();
    test_frame_clear();
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/delay_sa.md
Name: delay_sa

Overview:
- Delay stage of the synthetic-aperture beamformer, directly upstream of summ_sa.
- Each accepted beat stores one sample per channel into a per-channel circular buffer.
- It then applies a programmable per-channel integer delay (in beats).
- It serialises the delayed samples to summ_sa as: start_sum pulse, NUM_CHANNELS cycles of sum_en with delayed_sample, then a done_channel pulse.

Parameters:
- DATA_WIDTH, 16, sample width (matches summ_sa DATA_WIDTH).
- NUM_CHANNELS, 4, channels per beat (matches summ_sa NUM_CHANNELS); must be ≥2.
- MAX_DELAY, 16, buffer depth per channel; legal delays are 0..MAX_DELAY-1.
- DLY_W, $clog2(MAX_DELAY), delay field width.
- CH_W, $clog2(NUM_CHANNELS), channel index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_frame  in  1  new-frame strobe; clears history.
- sample_valid  in  1  beat present on sample_in.
- sample_ready  out  1  beat accepted when sample_valid && sample_ready.
- sample_in  in  NUM_CHANNELS*DATA_WIDTH  packed beat; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- delay_wr_en  in  1  delay table write strobe.
- delay_wr_ch  in  CH_W  channel to write.
- delay_wr_val  in  DLY_W  delay in beats.
- busy  out  1  high whenever state != IDLE.
- start_sum  out  1  one-cycle pulse to summ_sa.
- sum_en  out  1  delayed_sample valid.
- delayed_sample  out  DATA_WIDTH  delayed channel sample.
- done_channel  out  1  one-cycle pulse; summ_sa latches its sum.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; wr_ptr=0; fill=0; ch=0; delay table all 0; buffer contents don't care.
  - Outputs: sample_ready=1 (combinational from IDLE), busy=0, start_sum=0, sum_en=0, delayed_sample=0, done_channel=0.
  - Reset mid-sequence aborts immediately; no done_channel is issued.
- FSM: IDLE -> START -> EMIT (NUM_CHANNELS cycles) -> DONE -> IDLE. All outputs are registered except sample_ready.
- IDLE: sample_ready=1.
  - On accept: write sample_in[k] to buf[k][wr_ptr] for all k; cur_ptr<=wr_ptr; wr_ptr<=(wr_ptr+1) mod MAX_DELAY; fill<=min(fill+1, MAX_DELAY); go START.
- START: start_sum=1 for exactly one cycle; ch<=0.
- EMIT: sum_en=1 and delayed_sample=out(ch); ch increments every cycle; after ch=NUM_CHANNELS-1 go DONE.
  - out(ch) = buf[ch][(cur_ptr - delay[ch]) mod MAX_DELAY] if fill > delay[ch], else 0.
  - The modulo is explicit: if cur_ptr >= d then cur_ptr-d, else cur_ptr+MAX_DELAY-d. MAX_DELAY need not be a power of 2.
- DONE: done_channel=1 for one cycle; sum_en=0; delayed_sample=0; go IDLE.
- Timing: accept on edge t -> start_sum high in cycle t+1 -> sum_en high in cycles t+2..t+N+1 (channel 0 first) -> done_channel in cycle t+N+2 -> sample_ready high again in cycle t+N+3.
  - Throughput: one beat per NUM_CHANNELS+3 cycles.
- delayed_sample is 0 whenever sum_en=0.
- start_frame in IDLE: fill<=0, wr_ptr<=0 (delay table kept).
  - start_frame and accept in the same cycle: the clear applies first, then the beat is written at index 0 with fill=1.
  - start_frame while busy is ignored.
- Delay table writes:
  - Accepted only in IDLE and only when delay_wr_ch < NUM_CHANNELS; otherwise ignored (table unchanged).
  - A write in the same cycle as an accept takes effect for that beat's emission.
- fill saturates at MAX_DELAY. wr_ptr wraps MAX_DELAY-1 -> 0.

Test Plan:
- Reset: assert reset=0 mid-EMIT -> all outputs 0 and sample_ready=1 within the same cycle (async); on the next accept the first emitted samples are 0 for any channel with delay>0.
- Zero delay: delays all 0; beat {ch3..ch0}={5230,125,20,237} -> start_sum at t+1; sum_en with delayed_sample 237,20,125,5230 at t+2..t+5; done_channel at t+6. A chained summ_sa reports 5612.
- Per-channel delay: delays {0,1,2,3}; beats b0..b3 with chK value = 100*beat+K.
  - Beat 3 emission -> 300, 201, 102, 3.
  - Beat 0 emission -> 0, 0, 0, 0 except ch0=0 (value 0).
  - Beat 1 ch1 -> 1.
- Wrap-around: MAX_DELAY=16, delay[2]=15; stream 40 beats with ch2 = beat index -> from beat 15 on, ch2 output = beat-15 (beat 39 -> 24); beats 0..14 -> 0.
- Handshake/boundaries:
  - sample_valid held high continuously -> exactly one accept per 7 cycles (N=4).
  - start_frame while busy -> ignored.
  - start_frame with accept in IDLE -> history cleared; delayed channels output 0.
  - Delay write with delay_wr_ch while busy -> table unchanged.
